pool1_exec: RTL and testbench
=============================

# pool1_exec

Max-pooling stage for LeNet layer S2, sitting directly downstream of the C1 bias/activation stage. Consumes the six 16-bit signed C1 feature-map streams (f2 write data, one pixel per channel per accepted beat, raster order over a 24x24 map). Produces six 12x12 maps using 2x2 stride-2 max pooling, with a write address for the S2 feature-map memories. All six channels are processed in lockstep with shared counters.

## Interface
- IN_W, 24, input map width (even)
- IN_H, 24, input map height (even)
- DW, 16, data width (two's complement)
- AW, 8, output address width (must hold (IN_W/2)*(IN_H/2)-1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  C1 pixel beat valid for all six channels
- f2_1_wdata .. f2_6_wdata  in  DW each  C1 output pixel, channel 1..6, signed
- s2_1_wdata .. s2_6_wdata  out  DW each  pooled pixel, channel 1..6, signed
- s2_wen  out  1  pooled pixel valid / S2 memory write enable
- s2_waddr  out  AW  pooled pixel address, row-major, 0..(IN_W/2)*(IN_H/2)-1
- frame_done  out  1  one-cycle pulse coincident with the last s2_wen of a frame

## Operation
- Counters: col (0..IN_W-1), row (0..IN_H-1). They advance only on in_valid. col wraps to 0 at IN_W-1 and increments row. row wraps to 0 after (IN_H-1, IN_W-1); the next frame starts immediately, with no idle cycle required.
- Per channel: hold register h, and line buffer lb[IN_W/2] of DW bits.
- Beat at even col: h <= in.
- Beat at odd col: m = signed max(h, in).
  - Even row: lb[col>>1] <= m.
  - Odd row: output = signed max(lb[col>>1], m). It is registered into s2_k_wdata, with s2_wen=1 and s2_waddr = (row>>1)*(IN_W/2) + (col>>1).
- Comparisons are signed over the full DW bits. On ties either operand is correct, since the values are equal. No saturation or width change occurs.
- frame_done=1 together with s2_wen for the beat at row=IN_H-1, col=IN_W-1.
- Gaps in in_valid are allowed anywhere, including inside a 2x2 window. State is held across gaps.
- in_valid is ignored while rst=1.

## Timing
- Latency: s2_wen is asserted in the cycle after the clock edge that accepts the beat at an odd-row, odd-col position. Equivalently, outputs are registered one cycle after the input.
- s2_wen is asserted for exactly one cycle per window. Outputs hold their last value while s2_wen=0.
- Throughput: one input beat per cycle sustained. Output rate is at most one write every other cycle, and only during odd rows.
- Reset values: s2_k_wdata=0, s2_wen=0, s2_waddr=0, frame_done=0, col=row=0. h and lb are not required to clear.
- Reset mid-frame: the partial frame is discarded. The first beat after reset is treated as pixel (0,0). No s2_wen is issued for windows that were incomplete at reset.
- No backpressure exists. The downstream S2 memories must accept every s2_wen.

## Test plan
- Ramp: channel 1 pixel = row*24+col over a full frame. Expect 144 writes, addr k=(r*12+c) carrying (2r+1)*24+(2c+1). frame_done fires once, on addr 143.
- Negative ramp: channel 2 pixel = -(row*24+col). Expect the value at addr k = -(2r*24+2c). This checks the signed compare, e.g. addr 0 = 0, addr 1 = -2, addr 143 = -550.
- Mixed sign extremes: a single window holding 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000 produces 16'h7FFF. All six channels receive distinct patterns and each output matches an independent golden model.
- Gapped input: random in_valid with a duty of about 40% over a full frame. Output values and addresses are identical to the gap-free run, and each s2_wen occurs exactly one cycle after its completing beat.
- Reset mid-frame: assert rst for 1 cycle after 300 beats, then send a full ramp frame. Expect no s2_wen during or immediately after rst, then exactly 144 correct writes starting at addr 0.
- Back-to-back frames: two frames with continuous in_valid, where frame 2 = frame 1 + 1000. Expect 288 writes, addresses wrapping 143 → 0 without a gap, and two frame_done pulses.

Source files
------------

// File: rtl/pool1_exec.sv
// 2x2 stride-2 signed max pooling over six lockstep pixel streams (LeNet S2).
// Even rows fold pairs into a half-width line buffer; odd rows complete windows and write out.
module pool1_exec #(
  parameter int unsigned IN_W = 24,
  parameter int unsigned IN_H = 24,
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] f2_1_wdata,
  input  logic signed [DW-1:0] f2_2_wdata,
  input  logic signed [DW-1:0] f2_3_wdata,
  input  logic signed [DW-1:0] f2_4_wdata,
  input  logic signed [DW-1:0] f2_5_wdata,
  input  logic signed [DW-1:0] f2_6_wdata,
  output logic signed [DW-1:0] s2_1_wdata,
  output logic signed [DW-1:0] s2_2_wdata,
  output logic signed [DW-1:0] s2_3_wdata,
  output logic signed [DW-1:0] s2_4_wdata,
  output logic signed [DW-1:0] s2_5_wdata,
  output logic signed [DW-1:0] s2_6_wdata,
  output logic                 s2_wen,
  output logic [AW-1:0]        s2_waddr,
  output logic                 frame_done
);

  localparam int unsigned NCH = 6;
  localparam int unsigned HW  = IN_W / 2;
  localparam int unsigned CW  = $clog2(IN_W);
  localparam int unsigned RW  = $clog2(IN_H);

  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic signed [DW-1:0] px    [NCH];
  logic signed [DW-1:0] h_q   [NCH];
  logic signed [DW-1:0] lb_q  [NCH][HW];
  logic signed [DW-1:0] m     [NCH];
  logic signed [DW-1:0] pool  [NCH];
  logic signed [DW-1:0] out_q [NCH];
  logic                 col_last;
  logic                 row_last;
  logic [CW-2:0]        lb_idx;
  logic [AW-1:0]        addr;

  assign px[0] = f2_1_wdata;
  assign px[1] = f2_2_wdata;
  assign px[2] = f2_3_wdata;
  assign px[3] = f2_4_wdata;
  assign px[4] = f2_5_wdata;
  assign px[5] = f2_6_wdata;

  assign s2_1_wdata = out_q[0];
  assign s2_2_wdata = out_q[1];
  assign s2_3_wdata = out_q[2];
  assign s2_4_wdata = out_q[3];
  assign s2_5_wdata = out_q[4];
  assign s2_6_wdata = out_q[5];

  assign col_last = (col_q == CW'(IN_W - 1));
  assign row_last = (row_q == RW'(IN_H - 1));
  assign lb_idx   = col_q[CW-1:1];
  assign addr     = AW'(32'(row_q[RW-1:1]) * HW + 32'(lb_idx));

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      m[k]    = (h_q[k] > px[k]) ? h_q[k] : px[k];
      pool[k] = (lb_q[k][lb_idx] > m[k]) ? lb_q[k][lb_idx] : m[k];
    end
  end

  // Datapath storage needs no reset: every window rewrites it before it is read.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      for (int k = 0; k < NCH; k++) begin
        if (!col_q[0]) begin
          h_q[k] <= px[k];
        end else if (!row_q[0]) begin
          lb_q[k][lb_idx] <= m[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      s2_wen     <= 1'b0;
      s2_waddr   <= '0;
      frame_done <= 1'b0;
      for (int k = 0; k < NCH; k++) out_q[k] <= '0;
    end else begin
      s2_wen     <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (col_q[0] && row_q[0]) begin
          s2_wen     <= 1'b1;
          s2_waddr   <= addr;
          frame_done <= col_last && row_last;
          for (int k = 0; k < NCH; k++) out_q[k] <= pool[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pool1_exec.sv
// Bench for pool1_exec: whole frames are pooled by a plain 2x2-max model and
// compared record-by-record (address, data, frame_done, output cycle) with the DUT.
module tb_pool1_exec;

  localparam int W    = 24;
  localparam int H    = 24;
  localparam int NCH  = 6;
  localparam int NOUT = (W / 2) * (H / 2);
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [7:0]       addr;
    logic             fd;
    logic [31:0]      t;
    logic [5:0][15:0] d;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] f2 [NCH];
  logic signed [15:0] s2 [NCH];
  logic s2_wen;
  logic frame_done;
  logic [7:0] s2_waddr;

  logic signed [15:0] pix [2][NCH][H][W];
  int unsigned stamp [2][H][W];
  int unsigned ecount = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];
  int stray_fd = 0;
  int checks = 0;
  int errors = 0;
  int n;
  int fdc;

  pool1_exec dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .f2_1_wdata (f2[0]),
    .f2_2_wdata (f2[1]),
    .f2_3_wdata (f2[2]),
    .f2_4_wdata (f2[3]),
    .f2_5_wdata (f2[4]),
    .f2_6_wdata (f2[5]),
    .s2_1_wdata (s2[0]),
    .s2_2_wdata (s2[1]),
    .s2_3_wdata (s2[2]),
    .s2_4_wdata (s2[3]),
    .s2_5_wdata (s2[4]),
    .s2_6_wdata (s2[5]),
    .s2_wen     (s2_wen),
    .s2_waddr   (s2_waddr),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  // Outputs are sampled on the falling edge, half a cycle clear of the active edge.
  always @(negedge clk) begin
    rec_t r;
    if (s2_wen) begin
      r.addr = s2_waddr;
      r.fd   = frame_done;
      r.t    = ecount;
      for (int k = 0; k < NCH; k++) r.d[k] = s2[k];
      obs_q.push_back(r);
    end else if (frame_done) begin
      stray_fd++;
    end
  end

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic fill_rand(input int f);
    for (int k = 0; k < NCH; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          pix[f][k][r][c] = 16'(int'($urandom_range(32000)) - 16000);
  endtask

  task automatic build_exp(input int f);
    rec_t e;
    for (int r2 = 0; r2 < H / 2; r2++) begin
      for (int c2 = 0; c2 < W / 2; c2++) begin
        e.addr = 8'(r2 * (W / 2) + c2);
        e.fd   = (r2 * (W / 2) + c2) == NOUT - 1;
        e.t    = stamp[f][2*r2+1][2*c2+1];
        for (int k = 0; k < NCH; k++)
          e.d[k] = smax(smax(pix[f][k][2*r2][2*c2], pix[f][k][2*r2][2*c2+1]),
                        smax(pix[f][k][2*r2+1][2*c2], pix[f][k][2*r2+1][2*c2+1]));
        exp_q.push_back(e);
      end
    end
  endtask

  // Beats are applied at the falling edge and accepted at the next rising edge.
  task automatic drive_frame(input int f, input int duty, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      while (int'($urandom_range(99)) >= duty) begin
        in_valid = 1'b0;
        for (int k = 0; k < NCH; k++) f2[k] = 16'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      for (int k = 0; k < NCH; k++) f2[k] = pix[f][k][i / W][i % W];
      stamp[f][i / W][i % W] = ecount + 1;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic prep();
    idle(2);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < NCH; k++) f2[k] = 16'($urandom);
    repeat (3) @(negedge clk);
    checks++; if (s2_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", s2_wen); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    checks++; if (s2_waddr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", s2_waddr); end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (s2[k] !== 16'd0) begin errors++; $display("FAIL reset_data[%0d] got %h want 0000", k, s2[k]); end
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_ramp();
    prep();
    fill_rand(0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pix[0][0][r][c] = 16'(r * W + c);
        pix[0][1][r][c] = 16'(-(r * W + c));
      end
    drive_frame(0, 100, NPIX);
    idle(3);
    build_exp(0);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ramp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ramp_rec[%0d] got addr %0d fd %0b t %0d d %h want addr %0d fd %0b t %0d d %h",
                 i, obs_q[i].addr, obs_q[i].fd, obs_q[i].t, obs_q[i].d,
                 exp_q[i].addr, exp_q[i].fd, exp_q[i].t, exp_q[i].d);
      end
    end
    if (obs_q.size() == NOUT) begin
      checks++; if (obs_q[0].d[0] !== 16'd25) begin errors++; $display("FAIL ramp_a0 got %0d want 25", obs_q[0].d[0]); end
      checks++; if (obs_q[143].d[0] !== 16'd575) begin errors++; $display("FAIL ramp_a143 got %0d want 575", obs_q[143].d[0]); end
      checks++; if (obs_q[0].d[1] !== 16'd0) begin errors++; $display("FAIL neg_a0 got %h want 0000", obs_q[0].d[1]); end
      checks++; if (obs_q[1].d[1] !== 16'hFFFE) begin errors++; $display("FAIL neg_a1 got %h want fffe", obs_q[1].d[1]); end
      checks++; if (obs_q[143].d[1] !== 16'hFDDA) begin errors++; $display("FAIL neg_a143 got %h want fdda", obs_q[143].d[1]); end
    end
    fdc = 0;
    foreach (obs_q[i]) if (obs_q[i].fd) fdc++;
    checks++; if (fdc != 1) begin errors++; $display("FAIL ramp_fd_count got %0d want 1", fdc); end
    // Outputs must hold the last window while idle.
    checks++; if (s2_wen !== 1'b0) begin errors++; $display("FAIL hold_wen got %b want 0", s2_wen); end
    checks++; if (s2_waddr !== 8'd143) begin errors++; $display("FAIL hold_addr got %0d want 143", s2_waddr); end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (s2[k] !== exp_q[NOUT-1].d[k]) begin
        errors++; $display("FAIL hold_data[%0d] got %h want %h", k, s2[k], exp_q[NOUT-1].d[k]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] ext [4];
    ext[0] = 16'h8000; ext[1] = 16'h7FFF; ext[2] = 16'hFFFF; ext[3] = 16'h0000;
    prep();
    fill_rand(0);
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < 4; j++)
        pix[0][k][2*k + j/2][2*k + j%2] = ext[(j + k) % 4];
    drive_frame(0, 100, NPIX);
    idle(3);
    build_exp(0);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ext_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ext_rec[%0d] got addr %0d fd %0b t %0d d %h want addr %0d fd %0b t %0d d %h",
                 i, obs_q[i].addr, obs_q[i].fd, obs_q[i].t, obs_q[i].d,
                 exp_q[i].addr, exp_q[i].fd, exp_q[i].t, exp_q[i].d);
      end
    end
    if (obs_q.size() == NOUT) begin
      for (int k = 0; k < NCH; k++) begin
        checks++;
        if (obs_q[k * 13].d[k] !== 16'h7FFF) begin
          errors++; $display("FAIL ext_win[%0d] got %h want 7fff", k, obs_q[k * 13].d[k]);
        end
      end
    end
  endtask

  task automatic test_gapped();
    prep();
    fill_rand(0);
    drive_frame(0, 40, NPIX);
    idle(3);
    build_exp(0);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL gap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_rec[%0d] got addr %0d fd %0b t %0d d %h want addr %0d fd %0b t %0d d %h",
                 i, obs_q[i].addr, obs_q[i].fd, obs_q[i].t, obs_q[i].d,
                 exp_q[i].addr, exp_q[i].fd, exp_q[i].t, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    prep();
    fill_rand(0);
    fill_rand(1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[1][0][r][c] = 16'(r * W + c);
    drive_frame(0, 100, 300);
    idle(2);
    obs_q.delete();
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (s2_wen !== 1'b0) begin errors++; $display("FAIL rstmid_wen got %b want 0", s2_wen); end
    checks++; if (s2_waddr !== 8'd0) begin errors++; $display("FAIL rstmid_addr got %0d want 0", s2_waddr); end
    drive_frame(1, 100, NPIX);
    idle(3);
    build_exp(1);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_rec[%0d] got addr %0d fd %0b t %0d d %h want addr %0d fd %0b t %0d d %h",
                 i, obs_q[i].addr, obs_q[i].fd, obs_q[i].t, obs_q[i].d,
                 exp_q[i].addr, exp_q[i].fd, exp_q[i].t, exp_q[i].d);
      end
    end
  endtask

  task automatic test_back_to_back();
    prep();
    fill_rand(0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[0][0][r][c] = 16'(r * W + c);
    for (int k = 0; k < NCH; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) pix[1][k][r][c] = pix[0][k][r][c] + 16'sd1000;
    drive_frame(0, 100, NPIX);
    drive_frame(1, 100, NPIX);
    idle(3);
    build_exp(0);
    build_exp(1);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_rec[%0d] got addr %0d fd %0b t %0d d %h want addr %0d fd %0b t %0d d %h",
                 i, obs_q[i].addr, obs_q[i].fd, obs_q[i].t, obs_q[i].d,
                 exp_q[i].addr, exp_q[i].fd, exp_q[i].t, exp_q[i].d);
      end
    end
    fdc = 0;
    foreach (obs_q[i]) if (obs_q[i].fd) fdc++;
    checks++; if (fdc != 2) begin errors++; $display("FAIL b2b_fd_count got %0d want 2", fdc); end
    checks++; if (stray_fd != 0) begin errors++; $display("FAIL stray_fd got %0d want 0", stray_fd); end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) f2[k] = '0;
    test_reset();
    test_ramp();
    test_extremes();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
